// File: rtl/register_file_param.sv
// Parametrised register file: two registered read ports, a registered inspect port,
// write-first bypass, optional hardwired-zero register 0 and a sequential post-reset clear engine.
module register_file_param #(
  parameter int             N         = 16,
  parameter int             M         = 3,
  parameter int             ZERO_REG  = 0,
  parameter logic [N-1:0]   CLEAR_VAL = '0
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Reg_Write,
  input  logic [M-1:0] Reg_write_ad,
  input  logic [N-1:0] Reg_write_data,
  input  logic [M-1:0] Reg_read_ad_1,
  input  logic [M-1:0] Reg_read_ad_2,
  output logic [N-1:0] Reg_read_data_1,
  output logic [N-1:0] Reg_read_data_2,
  input  logic         inr_check,
  input  logic [M-1:0] inr,
  output logic [N-1:0] outvalue,
  output logic         Busy
);

  localparam int           DEPTH = 2 ** M;
  localparam logic [M-1:0] LAST  = M'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [M-1:0]   r_clr_cnt;
  logic           r_busy;
  logic [N-1:0]   r_mem [DEPTH];
  logic [N-1:0]   r_rd1;
  logic [N-1:0]   r_rd2;
  logic [N-1:0]   r_outvalue;

  logic           w_ready;
  logic           w_wr_en;
  logic [N-1:0]   w_rd1;
  logic [N-1:0]   w_rd2;
  logic [N-1:0]   w_rdi;

  assign w_ready = (r_state == S_READY);
  // A write to register 0 is discarded entirely when it is hardwired to zero.
  assign w_wr_en = w_ready && Reg_Write && !((ZERO_REG != 0) && (Reg_write_ad == '0));

  function automatic logic [N-1:0] rd_word(
    input logic [M-1:0] a,
    input logic         wr_en,
    input logic [M-1:0] wr_ad,
    input logic [N-1:0] wr_data,
    input logic [N-1:0] mem_word
  );
    logic [N-1:0] v;
    if (wr_en && (a == wr_ad))           v = wr_data;
    else if ((ZERO_REG != 0) && (a == '0)) v = '0;
    else                                  v = mem_word;
    return v;
  endfunction

  assign w_rd1 = rd_word(Reg_read_ad_1, w_wr_en, Reg_write_ad, Reg_write_data, r_mem[Reg_read_ad_1]);
  assign w_rd2 = rd_word(Reg_read_ad_2, w_wr_en, Reg_write_ad, Reg_write_data, r_mem[Reg_read_ad_2]);
  assign w_rdi = rd_word(inr,           w_wr_en, Reg_write_ad, Reg_write_data, r_mem[inr]);

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_CLEAR;
    else       r_state <= w_state_next;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if ((r_state == S_CLEAR) && (r_clr_cnt == LAST)) w_state_next = S_READY;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + M'(1);
      if (r_clr_cnt == LAST) r_busy <= 1'b0;
    end
  end

  // NOTE: the array has no reset branch; the clear engine initialises it over DEPTH cycles.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (r_state == S_CLEAR) r_mem[r_clr_cnt]    <= CLEAR_VAL;
      else if (w_wr_en)       r_mem[Reg_write_ad] <= Reg_write_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || (r_state == S_CLEAR)) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_outvalue <= '0;
    end else begin
      r_rd1 <= w_rd1;
      r_rd2 <= w_rd2;
      if (inr_check) r_outvalue <= w_rdi;
    end
  end

  assign Reg_read_data_1 = r_rd1;
  assign Reg_read_data_2 = r_rd2;
  assign outvalue        = r_outvalue;
  assign Busy            = r_busy;

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench for register_file_param: two instances (plain, and hardwired-zero with a
// non-zero clear value) driven in parallel and compared against an array-based reference model.
module tb_register_file_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b0;
  logic [2:0]  wa  = '0;
  logic [15:0] wd  = '0;
  logic [2:0]  ra1 = '0;
  logic [2:0]  ra2 = '0;
  logic        ic  = 1'b0;
  logic [2:0]  inr = '0;

  logic [15:0] rd1_0, rd2_0, ov_0, rd1_1, rd2_1, ov_1;
  logic        busy_0, busy_1;

  always #5 clk = ~clk;

  register_file_param #(.N(16), .M(3), .ZERO_REG(0), .CLEAR_VAL(16'h0000)) dut0 (
    .Clock(clk), .Reset(rst), .Reg_Write(we), .Reg_write_ad(wa), .Reg_write_data(wd),
    .Reg_read_ad_1(ra1), .Reg_read_ad_2(ra2), .Reg_read_data_1(rd1_0), .Reg_read_data_2(rd2_0),
    .inr_check(ic), .inr(inr), .outvalue(ov_0), .Busy(busy_0)
  );

  register_file_param #(.N(16), .M(3), .ZERO_REG(1), .CLEAR_VAL(16'h00A5)) dut1 (
    .Clock(clk), .Reset(rst), .Reg_Write(we), .Reg_write_ad(wa), .Reg_write_data(wd),
    .Reg_read_ad_1(ra1), .Reg_read_ad_2(ra2), .Reg_read_data_1(rd1_1), .Reg_read_data_2(rd2_1),
    .inr_check(ic), .inr(inr), .outvalue(ov_1), .Busy(busy_1)
  );

  typedef struct packed {
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] ov;
    logic        busy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: plain arrays plus a count of clear cycles still to run.
  logic [15:0] mm [2][8];
  int          clr_left [2];
  int          clr_idx  [2];
  logic [15:0] m_ov     [2];
  bit          m_valid = 1'b0;

  function automatic bit zr(input int k);
    return k == 1;
  endfunction

  function automatic logic [15:0] cv(input int k);
    return (k == 1) ? 16'h00A5 : 16'h0000;
  endfunction

  function automatic bit write_kept(input int k);
    return we && !(zr(k) && wa == 3'd0);
  endfunction

  function automatic logic [15:0] mrd(input int k, input logic [2:0] a);
    if (write_kept(k) && a == wa) return wd;
    if (zr(k) && a == 3'd0)       return 16'h0000;
    return mm[k][a];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e = '0;
      if (rst) begin
        clr_left[k] = 8;
        clr_idx[k]  = 0;
        m_ov[k]     = 16'h0000;
        e.busy      = 1'b1;
      end else if (!m_valid) begin
        continue;
      end else if (clr_left[k] > 0) begin
        mm[k][clr_idx[k]] = cv(k);
        clr_idx[k]++;
        clr_left[k]--;
        m_ov[k] = 16'h0000;
        e.busy  = (clr_left[k] > 0);
      end else begin
        e.rd1 = mrd(k, ra1);
        e.rd2 = mrd(k, ra2);
        if (ic) m_ov[k] = mrd(k, inr);
        e.ov = m_ov[k];
        if (write_kept(k)) mm[k][wa] = wd;
      end
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (rst) m_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    else             n_pass++;
  endtask

  // Monitor: every output cycle with a pending expectation is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check($sformatf("c%0d d0 rd1", cyc), rd1_0, e.rd1);
      check($sformatf("c%0d d0 rd2", cyc), rd2_0, e.rd2);
      check($sformatf("c%0d d0 outvalue", cyc), ov_0, e.ov);
      check($sformatf("c%0d d0 busy", cyc), {15'b0, busy_0}, {15'b0, e.busy});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check($sformatf("c%0d d1 rd1", cyc), rd1_1, e.rd1);
      check($sformatf("c%0d d1 rd2", cyc), rd2_1, e.rd2);
      check($sformatf("c%0d d1 outvalue", cyc), ov_1, e.ov);
      check($sformatf("c%0d d1 busy", cyc), {15'b0, busy_1}, {15'b0, e.busy});
    end
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    // Post-reset clear, with a write attempt on clear cycle 3 that must be dropped.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin we = 1'b1; wa = 3'd2; wd = 16'd7; end
      else        we = 1'b0;
      tick();
    end
    we = 1'b0;
    for (int a = 0; a < 8; a++) begin
      ra1 = 3'(a); ra2 = 3'(7 - a); ic = 1'b1; inr = 3'(a);
      tick();
    end

    // Basic write, read and inspect, including inspect hold.
    wr(3'd0, 16'd20); wr(3'd1, 16'd10); wr(3'd5, 16'd30);
    ra1 = 3'd1; ra2 = 3'd5; ic = 1'b1; inr = 3'd0; tick();
    inr = 3'd5; tick();
    ic = 1'b0; inr = 3'd1; tick(); tick();

    // Write-first bypass on both read ports and the inspect port.
    ic = 1'b1; inr = 3'd3; ra1 = 3'd3; ra2 = 3'd3;
    wr(3'd3, 16'h1234);
    tick();

    // Register 0 writes, with bypass reads in the same cycle.
    ra1 = 3'd0; ra2 = 3'd0; inr = 3'd0;
    wr(3'd0, 16'hFFFF);
    ra1 = 3'd7; ra2 = 3'd0;
    wr(3'd7, 16'hFFFF);
    ra1 = 3'd0; ra2 = 3'd7; inr = 3'd7; tick();

    // Reset from READY, then reset in the middle of a clear.
    rst = 1'b1; tick(); rst = 1'b0;
    ra1 = 3'd5; ra2 = 3'd7; inr = 3'd5;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      we  = 1'($urandom_range(0, 1));
      wa  = 3'($urandom);
      wd  = 16'($urandom);
      ra1 = 3'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
      ic  = 1'($urandom_range(0, 1));
      inr = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
      tick();
    end
    rst = 1'b0; we = 1'b0;

    for (int i = 0; i < 10 && (q0.size() + q1.size()) > 0; i++) begin
      @(negedge clk); #1;
    end
    check("scoreboard drained", 16'(q0.size() + q1.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
